// File: rtl/sub16_pkg.sv
// Shared types and widths for the nibble-serial 16-bit subtractor.
package sub16_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

    localparam int WIDTH   = 16;
    localparam int NIB     = 4;
    localparam int NUM_NIB = 4;
endpackage

// File: rtl/sub_nibble.sv
// Combinational 4-bit subtract cell: d = a - b - bin, bout set on unsigned underflow.
module sub_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);
    logic [4:0] r;

    // The fifth bit of a zero-extended difference is the borrow-out.
    assign r    = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
    assign d    = r[3:0];
    assign bout = r[4];
endmodule

// File: rtl/nibble_serial_sub16.sv
// Sequential 16-bit subtractor: one nibble per cycle, LSB nibble first, with
// valid/ready handshakes and registered borrow/overflow/zero/neg flags.
module nibble_serial_sub16
    import sub16_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic             neg
);
    sub_state_t       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [3:0]       sh;
    logic [NIB-1:0]   nib_a, nib_b, nib_d;
    logic             nib_bout;

    // Single shared cell, fed by the nibble-select mux.
    assign sh    = {idx_q, 2'b00};
    assign nib_a = a_q[sh +: NIB];
    assign nib_b = b_q[sh +: NIB];

    sub_nibble u_sub_nibble (
        .a    (nib_a),
        .b    (nib_b),
        .bin  (br_q),
        .d    (nib_d),
        .bout (nib_bout)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        br_d       = br_q;
        a_d        = a_q;
        b_d        = b_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    idx_d   = 2'd0;
                    diff_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[sh +: NIB] = nib_d;
                br_d              = nib_bout;
                idx_d             = idx_q + 2'd1;
                if (idx_q == 2'(NUM_NIB - 1)) begin
                    // Flags use the top nibble being written this cycle.
                    borrow_d   = nib_bout;
                    overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (nib_d[NIB-1] != a_q[WIDTH-1]);
                    zero_d     = ({nib_d, diff_q[WIDTH-NIB-1:0]} == '0);
                    neg_d      = nib_d[NIB-1];
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            br_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            br_q       <= br_d;
            a_q        <= a_d;
            b_q        <= b_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
endmodule

// File: tb/tb_nibble_serial_sub16.sv
// Directed self-checking bench for nibble_serial_sub16.
module tb_nibble_serial_sub16;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow, overflow, zero, neg;

    int applied = 0;
    int errors  = 0;
    int cyc     = 0;

    nibble_serial_sub16 dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .overflow  (overflow),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        borrow;
        logic        overflow;
        logic        zero;
        logic        neg;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Bounded wait for out_valid; returns edges waited.
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            errors++;
            applied++;
            $display("FAIL wait_out: out_valid never rose within %0d cycles", n);
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, ".diff"},     {16'h0, diff},     {16'h0, v.diff});
        check({tag, ".borrow"},   {31'h0, borrow},   {31'h0, v.borrow});
        check({tag, ".overflow"}, {31'h0, overflow}, {31'h0, v.overflow});
        check({tag, ".zero"},     {31'h0, zero},     {31'h0, v.zero});
        check({tag, ".neg"},      {31'h0, neg},      {31'h0, v.neg});
    endtask

    initial begin
        int n;
        int t1, t2;
        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'hABCD, 16'h1111, 1'b0, 16'h9ABC, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{16'hF0F0, 16'h0F0F, 1'b0, 16'hE1E1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{16'h5555, 16'hAAAA, 1'b0, 16'hAAAB, 1'b1, 1'b1, 1'b0, 1'b1};

        Reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        check("rst.in_ready",  {31'h0, in_ready},  32'd1);
        check("rst.out_valid", {31'h0, out_valid}, 32'd0);
        check_result("rst", '{16'h0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});

        for (int i = 0; i < 10; i++) begin
            a = vecs[i].a; b = vecs[i].b; bin = vecs[i].bin; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check($sformatf("v%0d.busy", i), {31'h0, in_ready}, 32'd0);
            wait_out(n);
            check($sformatf("v%0d.latency", i), n, 32'd4);
            check_result($sformatf("v%0d", i), vecs[i]);
            check($sformatf("v%0d.excl", i), {31'h0, in_ready}, 32'd0);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check($sformatf("v%0d.idle", i), {30'h0, in_ready, out_valid}, 32'd2);
        end

        // Backpressure plus operands toggled while busy.
        a = 16'hABCD; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'h0000; b = 16'h0001; bin = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        wait_out(n);
        for (int k = 0; k < 3; k++) begin
            check_result($sformatf("bp%0d", k), vecs[4]);
            check($sformatf("bp%0d.in_ready", k), {31'h0, in_ready}, 32'd0);
            check($sformatf("bp%0d.out_valid", k), {31'h0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        check("bp.release", {30'h0, in_ready, out_valid}, 32'd2);

        // Reset in the second RUN cycle, after a result with flags set.
        a = 16'h0000; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mrst.in_ready",  {31'h0, in_ready},  32'd1);
        check("mrst.out_valid", {31'h0, out_valid}, 32'd0);
        check_result("mrst", '{16'h0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) n++;
            tick();
        end
        check("mrst.no_pulse", n, 32'd0);

        // Reset wins over a simultaneous in_valid.
        a = 16'h0005; b = 16'h0003; in_valid = 1'b1; Reset = 1'b1;
        tick();
        Reset = 1'b0; in_valid = 1'b0;
        check("rstv.in_ready", {31'h0, in_ready}, 32'd1);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) n++;
            tick();
        end
        check("rstv.no_accept", n, 32'd0);

        // Back-to-back with out_ready held high.
        out_ready = 1'b1;
        a = 16'h0005; b = 16'h0003; bin = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'hFFFF; b = 16'hFFFF;
        wait_out(n);
        t1 = cyc;
        check_result("b2b0", '{16'h0, 16'h0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0});
        tick();
        wait_out(n);
        t2 = cyc;
        in_valid = 1'b0;
        check_result("b2b1", '{16'h0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
        check("b2b.spacing", t2 - t1, 32'd6);
        tick();
        out_ready = 1'b0;
        check("b2b.idle", {30'h0, in_ready, out_valid}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end
endmodule
